// File: rtl/vlc_stream_sequencer_pkg.sv
// Shared types for the VLC stream sequencer: word/size widths, FIFO entry layouts and FSM states.
package vlc_stream_sequencer_pkg;

    localparam int VLC_W  = 64;
    localparam int SIZE_W = 64;

    typedef struct packed {
        logic [VLC_W-1:0]  val;
        logic [SIZE_W-1:0] size;
    } dc_entry_t;

    // The AC stream carries an in-band flush marker so it stays ordered behind the last AC word.
    typedef struct packed {
        logic              flush;
        logic [VLC_W-1:0]  val;
        logic [SIZE_W-1:0] size;
    } ac_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DC   = 2'd1,
        S_AC   = 2'd2
    } seq_state_e;

    function automatic ac_entry_t flush_marker();
        ac_entry_t e;
        e.flush = 1'b1;
        e.val   = '0;
        e.size  = '0;
        return e;
    endfunction

endpackage

// File: rtl/vlc_stream_sequencer_if.sv
// Producer-side and packer-side signal bundle of the VLC stream sequencer.
interface vlc_stream_sequencer_if;
    import vlc_stream_sequencer_pkg::*;

    logic              slice_start;
    logic              dc_enable;
    logic [VLC_W-1:0]  dc_val;
    logic [SIZE_W-1:0] dc_size_of_bit;
    logic              dc_done;
    logic              ac_enable;
    logic [VLC_W-1:0]  ac_val;
    logic [SIZE_W-1:0] ac_size_of_bit;
    logic              ac_flush_bit;
    logic              out_ready;
    logic              output_enable;
    logic [VLC_W-1:0]  val;
    logic [SIZE_W-1:0] size_of_bit;
    logic              flush_bit;
    logic              busy;
    logic              slice_done;
    logic              overflow;
    logic              protocol_error;

    modport master (
        output slice_start, dc_enable, dc_val, dc_size_of_bit, dc_done,
               ac_enable, ac_val, ac_size_of_bit, ac_flush_bit, out_ready,
        input  output_enable, val, size_of_bit, flush_bit, busy, slice_done,
               overflow, protocol_error
    );

    modport slave (
        input  slice_start, dc_enable, dc_val, dc_size_of_bit, dc_done,
               ac_enable, ac_val, ac_size_of_bit, ac_flush_bit, out_ready,
        output output_enable, val, size_of_bit, flush_bit, busy, slice_done,
               overflow, protocol_error
    );

endinterface

// File: rtl/vlc_stream_sequencer_word_fifo.sv
// Synchronous FIFO with up to two ordered pushes per cycle (a before b) and one pop.
// A push that finds no free slot is dropped and reported on o_drop.
module vlc_word_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push_a,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic             i_push_b,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic [CW-1:0]    w_free;
    logic             w_take_a;
    logic             w_take_b;
    logic [AW-1:0]    w_wr_ptr_b;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts one push.
    always_comb begin
        w_pop      = i_pop && (r_count != '0);
        w_free     = DEPTH_C - r_count + CW'(w_pop);
        w_take_a   = i_push_a && (w_free != '0);
        w_take_b   = i_push_b && (w_take_a ? (w_free > ONE_C) : (w_free != '0));
        w_wr_ptr_b = r_wr_ptr + AW'(w_take_a);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_take_a) + AW'(w_take_b);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_take_a) + CW'(w_take_b) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_take_a) begin
            r_mem[r_wr_ptr] <= i_data_a;
        end
        if (w_take_b) begin
            r_mem[w_wr_ptr_b] <= i_data_b;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_drop  = (i_push_a && !w_take_a) || (i_push_b && !w_take_b);

endmodule

// File: rtl/vlc_stream_sequencer.sv
// Orders the DC and AC VLC word streams of one slice onto the bit-packer input:
// all DC words, then all AC words, then the flush request.
module vlc_stream_sequencer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    vlc_stream_sequencer_if.slave bus
);
    import vlc_stream_sequencer_pkg::*;

    seq_state_e r_state;
    seq_state_e w_next_state;
    logic       r_dc_done_seen;
    ac_entry_t  r_out;
    logic       r_out_valid;
    logic       r_slice_done;
    logic       r_overflow;
    logic       r_protocol_error;

    dc_entry_t  w_dc_push_entry;
    ac_entry_t  w_ac_push_entry;
    dc_entry_t  w_dc_head;
    ac_entry_t  w_ac_head;
    logic       w_dc_empty;
    logic       w_ac_empty;
    logic       w_dc_drop;
    logic       w_ac_drop;

    logic       w_active;
    logic       w_busy;
    logic       w_slot_free;
    logic       w_dc_to_ac;
    logic       w_src_dc;
    logic       w_src_ac;
    logic       w_load;
    logic       w_pop_dc;
    logic       w_pop_ac;
    logic       w_flush_pop;
    logic       w_start;
    logic       w_proto_err;
    ac_entry_t  w_load_entry;

    assign w_active = (r_state != S_IDLE);
    // The flush word is still owned by the sequencer until the packer takes it.
    assign w_busy   = w_active || (r_out_valid && r_out.flush);

    assign w_dc_push_entry.val  = bus.dc_val;
    assign w_dc_push_entry.size = bus.dc_size_of_bit;
    assign w_ac_push_entry.flush = 1'b0;
    assign w_ac_push_entry.val   = bus.ac_val;
    assign w_ac_push_entry.size  = bus.ac_size_of_bit;

    vlc_word_fifo #(
        .WIDTH ($bits(dc_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_dc_fifo (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_push_a (bus.dc_enable && w_active),
        .i_data_a (w_dc_push_entry),
        .i_push_b (1'b0),
        .i_data_b ('0),
        .i_pop    (w_pop_dc),
        .o_data   (w_dc_head),
        .o_empty  (w_dc_empty),
        .o_drop   (w_dc_drop)
    );

    vlc_word_fifo #(
        .WIDTH ($bits(ac_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ac_fifo (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_push_a (bus.ac_enable && w_active),
        .i_data_a (w_ac_push_entry),
        .i_push_b (bus.ac_flush_bit && w_active),
        .i_data_b (flush_marker()),
        .i_pop    (w_pop_ac),
        .o_data   (w_ac_head),
        .o_empty  (w_ac_empty),
        .o_drop   (w_ac_drop)
    );

    always_comb begin
        w_next_state = r_state;
        w_slot_free  = !r_out_valid || bus.out_ready;
        // Switching in the same cycle the last DC word leaves the slot avoids a bubble.
        w_dc_to_ac   = (r_state == S_DC) && r_dc_done_seen && w_dc_empty && w_slot_free;
        w_src_dc     = (r_state == S_DC) && !w_dc_empty;
        w_src_ac     = ((r_state == S_AC) || w_dc_to_ac) && !w_ac_empty;
        w_load       = w_slot_free && (w_src_dc || w_src_ac);
        w_pop_dc     = w_load && w_src_dc;
        w_pop_ac     = w_load && w_src_ac;
        w_flush_pop  = w_pop_ac && w_ac_head.flush;
        w_start      = bus.slice_start && !w_busy;
        w_proto_err  = (bus.slice_start && w_busy) ||
                       (!w_active && (bus.dc_enable || bus.dc_done ||
                                      bus.ac_enable || bus.ac_flush_bit));

        w_load_entry = w_ac_head;
        if (w_src_dc) begin
            w_load_entry.flush = 1'b0;
            w_load_entry.val   = w_dc_head.val;
            w_load_entry.size  = w_dc_head.size;
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_DC;
                end
            end
            S_DC: begin
                if (w_flush_pop) begin
                    w_next_state = S_IDLE;
                end else if (w_dc_to_ac) begin
                    w_next_state = S_AC;
                end
            end
            S_AC: begin
                if (w_flush_pop) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dc_done_seen   <= 1'b0;
            r_out            <= '0;
            r_out_valid      <= 1'b0;
            r_slice_done     <= 1'b0;
            r_overflow       <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            if (w_start) begin
                r_dc_done_seen <= 1'b0;
            end else if ((r_state == S_DC) && bus.dc_done) begin
                r_dc_done_seen <= 1'b1;
            end

            if (w_load) begin
                r_out       <= w_load_entry;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
            end

            r_slice_done     <= w_flush_pop;
            r_overflow       <= r_overflow || w_dc_drop || w_ac_drop;
            r_protocol_error <= r_protocol_error || w_proto_err;
        end
    end

    assign bus.output_enable  = r_out_valid;
    assign bus.val            = r_out.val;
    assign bus.size_of_bit    = r_out.size;
    assign bus.flush_bit      = r_out.flush;
    assign bus.busy           = w_busy;
    assign bus.slice_done     = r_slice_done;
    assign bus.overflow       = r_overflow;
    assign bus.protocol_error = r_protocol_error;

endmodule
